// File: rtl/shift_rows_serial.sv
// AES (Inv)ShiftRows on a byte-serial column-major stream, 16-byte ping-pong banks.
// Latency: byte 0 of a block appears one edge after its 16th byte is accepted, then 15 more bytes back-to-back.
// Backpressure: in_ready drops only while the write bank is still full; the output side has no backpressure.
module shift_rows_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       in_valid,
    input  logic [7:0] d_in,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] d_out,
    output logic       out_en
);

    logic [7:0] mem [2][16];
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic [1:0] bank_mode;
    logic [3:0] wr_cnt;
    logic [3:0] rd_cnt;
    logic       wr_bank;
    logic       rd_bank;
    logic       wr_fire;
    logic       rd_fire;
    logic [1:0] rd_col;
    logic [1:0] rd_row;
    logic [1:0] src_col;
    logic [3:0] src_idx;

    assign in_ready = rst & ~full[wr_bank];
    assign wr_fire  = in_valid & in_ready;
    assign rd_fire  = full[rd_bank];

    // Column arithmetic wraps naturally in 2 bits, giving the mod-4 rotation.
    assign rd_col  = rd_cnt[3:2];
    assign rd_row  = rd_cnt[1:0];
    assign src_col = bank_mode[rd_bank] ? (rd_col + rd_row) : (rd_col - rd_row);
    assign src_idx = {src_col, rd_row};

    // A bank being written is never full, so set and clear never collide on one flag.
    always_comb begin
        full_nxt = full;
        if (wr_fire && (wr_cnt == 4'd15)) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && (rd_cnt == 4'd15)) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt    <= 4'd0;
            rd_cnt    <= 4'd0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
            out_valid <= 1'b0;
            out_en    <= 1'b0;
            d_out     <= 8'h00;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 4'd1;
                if (wr_cnt == 4'd15) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 4'd1;
                if (rd_cnt == 4'd15) begin
                    rd_bank <= ~rd_bank;
                end
                d_out <= mem[rd_bank][src_idx];
            end
            out_valid <= rd_fire;
            out_en    <= rd_fire && (rd_row != 2'd0);
        end
    end

    // Data and latched mode are only consumed behind a full flag, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_cnt] <= d_in;
            if (wr_cnt == 4'd0) begin
                bank_mode[wr_bank] <= mode;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_serial.sv
// Randomized and directed bench for shift_rows_serial against a row-rotation reference model.
module tb_shift_rows_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] d_out;
    logic       out_en;

    typedef logic [7:0] blk_t [16];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_acc = 0;
    int first_acc = 0;
    int ready_waits = 0;
    int idle_en_errs = 0;

    logic [7:0] oq [$];
    logic       eq [$];
    int         cq [$];

    blk_t enc_in  = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                      8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    blk_t enc_out = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                      8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

    shift_rows_serial dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .d_in     (d_in),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .d_out    (d_out),
        .out_en   (out_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && out_valid) begin
            oq.push_back(d_out);
            eq.push_back(out_en);
            cq.push_back(cyc);
        end
        if (!out_valid && out_en) idle_en_errs++;
    end

    // Row r of the state rotates left by r columns (encrypt) or right by r (decrypt).
    function automatic blk_t model(input blk_t blk, input logic m);
        blk_t res;
        for (int j = 0; j < 16; j++) begin
            int c;
            int r;
            int sc;
            c  = j / 4;
            r  = j % 4;
            sc = m ? (c + r) % 4 : (c - r + 4) % 4;
            res[j] = blk[4 * sc + r];
        end
        return res;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(255));
        return b;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        oq.delete();
        eq.delete();
        cq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic m);
        int w;
        w = 0;
        in_valid = 1'b1;
        d_in     = b;
        mode     = m;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            ready_waits++;
            w++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic send_block(input blk_t blk, input logic m, input int stall_after,
                              input int stall_len, input bit toggle);
        for (int i = 0; i < 16; i++) begin
            send_byte(blk[i], (toggle && i > 0) ? ~m : m);
            if (i == 0) first_acc = last_acc;
            if (i == stall_after) idle(stall_len);
        end
    endtask

    task automatic wait_out(input int n, output bit ok);
        int w;
        w = 0;
        while (oq.size() < n && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        ok = (oq.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++;
        if (out_en !== 1'b0) $display("FAIL reset_out_en got=%b want=0", out_en); else n_pass++;
        n_checks++;
        if (d_out !== 8'h00) $display("FAIL reset_d_out got=%h want=00", d_out); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got=%b want=0", out_valid); else n_pass++;
        idle(1);
    endtask

    task automatic test_encrypt();
        bit ok;
        clear_q();
        send_block(enc_in, 1'b1, -1, 0, 1'b0);
        wait_out(16, ok);
        n_checks++;
        if (!ok) $display("FAIL enc_timeout got=%0d bytes want=16", oq.size()); else n_pass++;
        if (ok) begin
            for (int j = 0; j < 16; j++) begin
                n_checks++;
                if (oq[j] !== enc_out[j]) $display("FAIL enc_byte%0d got=%h want=%h", j, oq[j], enc_out[j]);
                else n_pass++;
                n_checks++;
                if (eq[j] !== (j % 4 != 0)) $display("FAIL enc_out_en%0d got=%b want=%b", j, eq[j], (j % 4 != 0));
                else n_pass++;
            end
            n_checks++;
            if (cq[0] !== last_acc + 1) $display("FAIL enc_latency got=%0d want=%0d", cq[0], last_acc + 1);
            else n_pass++;
            n_checks++;
            if (cq[15] !== last_acc + 16) $display("FAIL enc_last_cycle got=%0d want=%0d", cq[15], last_acc + 16);
            else n_pass++;
        end
        idle(3);
    endtask

    task automatic test_decrypt();
        bit ok;
        clear_q();
        send_block(enc_out, 1'b0, -1, 0, 1'b0);
        wait_out(16, ok);
        n_checks++;
        if (!ok) $display("FAIL dec_timeout got=%0d bytes want=16", oq.size()); else n_pass++;
        if (ok) begin
            for (int j = 0; j < 16; j++) begin
                n_checks++;
                if (oq[j] !== enc_in[j]) $display("FAIL dec_byte%0d got=%h want=%h", j, oq[j], enc_in[j]);
                else n_pass++;
            end
        end
        idle(3);
    endtask

    task automatic test_random();
        bit ok;
        blk_t b;
        blk_t exp;
        logic m;
        for (int k = 0; k < 6; k++) begin
            clear_q();
            b   = rand_blk();
            m   = 1'($urandom_range(1));
            exp = model(b, m);
            send_block(b, m, $urandom_range(15), $urandom_range(3), 1'b0);
            wait_out(16, ok);
            n_checks++;
            if (!ok) $display("FAIL rand%0d_timeout got=%0d bytes want=16", k, oq.size()); else n_pass++;
            if (ok) begin
                for (int j = 0; j < 16; j++) begin
                    n_checks++;
                    if (oq[j] !== exp[j]) $display("FAIL rand%0d_byte%0d got=%h want=%h", k, j, oq[j], exp[j]);
                    else n_pass++;
                end
                n_checks++;
                if (cq[0] !== last_acc + 1) $display("FAIL rand%0d_latency got=%0d want=%0d", k, cq[0], last_acc + 1);
                else n_pass++;
            end
            idle(3);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        blk_t b [3];
        blk_t exp;
        logic ms [3];
        int gaps;
        ms = '{1'b1, 1'b0, 1'b1};
        clear_q();
        ready_waits = 0;
        for (int k = 0; k < 3; k++) b[k] = rand_blk();
        for (int k = 0; k < 3; k++) send_block(b[k], ms[k], -1, 0, 1'b0);
        wait_out(48, ok);
        n_checks++;
        if (ready_waits !== 0) $display("FAIL b2b_in_ready_low got=%0d cycles want=0", ready_waits); else n_pass++;
        n_checks++;
        if (!ok) $display("FAIL b2b_timeout got=%0d bytes want=48", oq.size()); else n_pass++;
        if (ok) begin
            gaps = 0;
            for (int j = 1; j < 48; j++) if (cq[j] != cq[j - 1] + 1) gaps++;
            n_checks++;
            if (gaps !== 0) $display("FAIL b2b_gapless got=%0d gaps want=0", gaps); else n_pass++;
            for (int k = 0; k < 3; k++) begin
                exp = model(b[k], ms[k]);
                for (int j = 0; j < 16; j++) begin
                    n_checks++;
                    if (oq[16 * k + j] !== exp[j])
                        $display("FAIL b2b_blk%0d_byte%0d got=%h want=%h", k, j, oq[16 * k + j], exp[j]);
                    else n_pass++;
                end
            end
        end
        idle(3);
    endtask

    task automatic test_stall();
        bit ok;
        clear_q();
        send_block(enc_in, 1'b1, 7, 3, 1'b0);
        wait_out(16, ok);
        n_checks++;
        if (!ok) $display("FAIL stall_timeout got=%0d bytes want=16", oq.size()); else n_pass++;
        n_checks++;
        if (last_acc - first_acc !== 18) $display("FAIL stall_span got=%0d want=18", last_acc - first_acc);
        else n_pass++;
        if (ok) begin
            for (int j = 0; j < 16; j++) begin
                n_checks++;
                if (oq[j] !== enc_out[j]) $display("FAIL stall_byte%0d got=%h want=%h", j, oq[j], enc_out[j]);
                else n_pass++;
            end
            n_checks++;
            if (cq[0] !== last_acc + 1) $display("FAIL stall_latency got=%0d want=%0d", cq[0], last_acc + 1);
            else n_pass++;
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        bit ok;
        blk_t junk;
        clear_q();
        junk = rand_blk();
        for (int i = 0; i < 10; i++) send_byte(junk[i], 1'b0);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        send_block(enc_in, 1'b1, -1, 0, 1'b0);
        n_checks++;
        if (oq.size() !== 0) $display("FAIL rstmid_early_out got=%0d bytes want=0", oq.size()); else n_pass++;
        wait_out(16, ok);
        idle(20);
        n_checks++;
        if (oq.size() !== 16) $display("FAIL rstmid_count got=%0d bytes want=16", oq.size()); else n_pass++;
        if (ok) begin
            for (int j = 0; j < 16; j++) begin
                n_checks++;
                if (oq[j] !== enc_out[j]) $display("FAIL rstmid_byte%0d got=%h want=%h", j, oq[j], enc_out[j]);
                else n_pass++;
            end
            n_checks++;
            if (cq[0] !== last_acc + 1) $display("FAIL rstmid_latency got=%0d want=%0d", cq[0], last_acc + 1);
            else n_pass++;
        end
    endtask

    task automatic test_mode_toggle();
        bit ok;
        clear_q();
        send_block(enc_in, 1'b1, -1, 0, 1'b1);
        wait_out(16, ok);
        n_checks++;
        if (!ok) $display("FAIL modetog_timeout got=%0d bytes want=16", oq.size()); else n_pass++;
        if (ok) begin
            for (int j = 0; j < 16; j++) begin
                n_checks++;
                if (oq[j] !== enc_out[j]) $display("FAIL modetog_byte%0d got=%h want=%h", j, oq[j], enc_out[j]);
                else n_pass++;
            end
        end
        idle(3);
    endtask

    task automatic test_idle_out_en();
        n_checks++;
        if (idle_en_errs !== 0) $display("FAIL idle_out_en got=%0d cycles want=0", idle_en_errs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_mode_toggle();
        test_idle_out_en();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
